// File: rtl/alien_bomb.sv
`default_nettype none
// ============================================================================
//  Module   : alien_bomb
//  Purpose  : Falling alien projectile: spawn, step-down, erase/redraw,
//             rocket hit detection and bottom-edge retirement.
//  Revision : 1.0 - initial release
// ============================================================================
module alien_bomb #(
    parameter int unsigned STEP_CYCLES     = 4,
    parameter int unsigned STEP_PIXELS     = 3,
    parameter int unsigned ROCKET_Y        = 105,
    parameter int unsigned ROCKET_W        = 8,
    parameter int unsigned BOTTOM_Y        = 119,
    parameter int unsigned COOLDOWN_CYCLES = 16,
    parameter logic [2:0]  BOMB_COLOUR     = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fireReq,
    input  logic [7:0] fireX,
    input  logic [6:0] fireY,
    input  logic [7:0] rocketX,
    input  logic       abort,
    output logic       fireAck,
    output logic [7:0] bombX,
    output logic [6:0] bombY,
    output logic [2:0] colour,
    output logic       drawEn,
    output logic       playerHit,
    output logic       busy
);

    localparam int unsigned c_cnt_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned c_cd_w  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_load    = c_cnt_w'(STEP_CYCLES - 1);
    localparam logic [c_cd_w-1:0]  c_cd_load     = c_cd_w'(COOLDOWN_CYCLES);
    localparam logic [7:0]         c_step_px     = 8'(STEP_PIXELS);
    localparam logic [6:0]         c_rocket_y    = 7'(ROCKET_Y);
    localparam logic [6:0]         c_bottom_y    = 7'(BOTTOM_Y);
    localparam logic [8:0]         c_rocket_w_m1 = 9'(ROCKET_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAW  = 3'd2,
        S_WAIT  = 3'd3,
        S_ERASE = 3'd4,
        S_MOVE  = 3'd5,
        S_CHECK = 3'd6,
        S_HIT   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          bomb_x_q, bomb_x_d;
    logic [6:0]          bomb_y_q, bomb_y_d;
    logic [2:0]          colour_q, colour_d;
    logic [c_cnt_w-1:0]  step_cnt_q, step_cnt_d;
    logic [c_cd_w-1:0]   cooldown_q, cooldown_d;
    logic                abort_pend_q, abort_pend_d;
    logic                busy_q;

    logic [7:0] w_y_sum;
    logic [6:0] w_y_stepped;
    logic [8:0] w_right;
    logic       w_rocket_hit;
    logic       w_retire;

    // Y advance saturates at the bottom of the 7-bit range instead of wrapping.
    assign w_y_sum     = {1'b0, bomb_y_q} + c_step_px;
    assign w_y_stepped = w_y_sum[7] ? 7'h7F : w_y_sum[6:0];

    // Right edge in 9 bits so a rocket near X=255 does not wrap to a miss.
    assign w_right      = {1'b0, rocketX} + c_rocket_w_m1;
    assign w_rocket_hit = (bomb_y_q >= c_rocket_y) && (bomb_x_q >= rocketX)
                          && ({1'b0, bomb_x_q} <= w_right);

    always_comb begin
        state_d      = state_q;
        bomb_x_d     = bomb_x_q;
        bomb_y_d     = bomb_y_q;
        colour_d     = colour_q;
        step_cnt_d   = step_cnt_q;
        cooldown_d   = cooldown_q;
        abort_pend_d = abort_pend_q;
        w_retire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cooldown_q != '0) cooldown_d = cooldown_q - 1'b1;
                if (fireReq && (cooldown_d == '0)) state_d = S_LOAD;
            end
            S_LOAD: begin
                bomb_x_d     = fireX;
                bomb_y_d     = fireY;
                abort_pend_d = abort;
                colour_d     = BOMB_COLOUR;
                state_d      = S_DRAW;
            end
            S_DRAW: begin
                step_cnt_d   = c_cnt_load;
                abort_pend_d = abort_pend_q | abort;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (step_cnt_q != '0) step_cnt_d = step_cnt_q - 1'b1;
                abort_pend_d = abort_pend_q | abort;
                if ((step_cnt_q == '0) || abort_pend_d) begin
                    colour_d = 3'b000;
                    state_d  = S_ERASE;
                end
            end
            S_ERASE: begin
                if (abort_pend_q) w_retire = 1'b1;
                else              state_d  = S_MOVE;
            end
            S_MOVE: begin
                bomb_y_d     = w_y_stepped;
                abort_pend_d = abort_pend_q | abort;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                abort_pend_d = abort_pend_q | abort;
                if (w_rocket_hit) begin
                    state_d = S_HIT;
                end else if (bomb_y_q > c_bottom_y) begin
                    w_retire = 1'b1;
                end else begin
                    colour_d = BOMB_COLOUR;
                    state_d  = S_DRAW;
                end
            end
            S_HIT: begin
                w_retire = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_retire) begin
            state_d      = S_IDLE;
            bomb_x_d     = '0;
            bomb_y_d     = '0;
            cooldown_d   = c_cd_load;
            abort_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bomb_x_q     <= '0;
            bomb_y_q     <= '0;
            colour_q     <= '0;
            step_cnt_q   <= '0;
            cooldown_q   <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bomb_x_q     <= bomb_x_d;
            bomb_y_q     <= bomb_y_d;
            colour_q     <= colour_d;
            step_cnt_q   <= step_cnt_d;
            cooldown_q   <= cooldown_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign fireAck   = (state_q == S_LOAD);
    assign drawEn    = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign playerHit = (state_q == S_HIT);
    assign busy      = busy_q;
    assign bombX     = bomb_x_q;
    assign bombY     = bomb_y_q;
    assign colour    = colour_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_bomb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alien_bomb
//  Purpose  : Directed scenarios plus randomized traffic for alien_bomb,
//             checked every cycle against a behavioural flight model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alien_bomb;

    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAW = 2, P_WAIT = 3;
    localparam int P_ERASE = 4, P_MOVE = 5, P_CHECK = 6, P_HIT = 7;
    localparam int STEP_CYCLES = 4, STEP_PIXELS = 3, ROCKET_Y = 105, ROCKET_W = 8;
    localparam int BOTTOM_Y = 119, COOLDOWN = 16, BOMB_COL = 5;

    logic       clk = 1'b0;
    logic       reset, fireReq, abort;
    logic [7:0] fireX, rocketX;
    logic [6:0] fireY;
    logic       fireAck, drawEn, playerHit, busy;
    logic [7:0] bombX;
    logic [6:0] bombY;
    logic [2:0] colour;

    always #5 clk = ~clk;

    alien_bomb dut (
        .clk      (clk),
        .reset    (reset),
        .fireReq  (fireReq),
        .fireX    (fireX),
        .fireY    (fireY),
        .rocketX  (rocketX),
        .abort    (abort),
        .fireAck  (fireAck),
        .bombX    (bombX),
        .bombY    (bombY),
        .colour   (colour),
        .drawEn   (drawEn),
        .playerHit(playerHit),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_ph = P_IDLE, m_x = 0, m_y = 0, m_col = 0, m_cool = 0, m_left = 0;
    bit m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_retire();
        m_ph   = P_IDLE;
        m_x    = 0;
        m_y    = 0;
        m_cool = COOLDOWN;
        m_pend = 1'b0;
    endtask

    // Advances the flight model across the coming clock edge using the driven inputs.
    task automatic model_step();
        bit abort_now;
        bit hit;
        if (!reset) begin
            m_ph = P_IDLE; m_x = 0; m_y = 0; m_col = 0; m_cool = 0; m_pend = 1'b0;
            return;
        end
        abort_now = abort && (m_ph == P_LOAD || m_ph == P_DRAW || m_ph == P_WAIT
                              || m_ph == P_MOVE || m_ph == P_CHECK);
        case (m_ph)
            P_IDLE: begin
                if (m_cool > 0) m_cool--;
                if (fireReq && m_cool == 0) m_ph = P_LOAD;
            end
            P_LOAD: begin
                m_x = int'(fireX); m_y = int'(fireY); m_pend = abort_now;
                m_col = BOMB_COL; m_ph = P_DRAW;
            end
            P_DRAW: begin
                m_left = STEP_CYCLES; m_pend = m_pend | abort_now; m_ph = P_WAIT;
            end
            P_WAIT: begin
                m_pend = m_pend | abort_now;
                m_left--;
                if (m_left == 0 || m_pend) begin m_ph = P_ERASE; m_col = 0; end
            end
            P_ERASE: begin
                if (m_pend) model_retire();
                else        m_ph = P_MOVE;
            end
            P_MOVE: begin
                m_y = (m_y + STEP_PIXELS > 127) ? 127 : m_y + STEP_PIXELS;
                m_pend = m_pend | abort_now;
                m_ph = P_CHECK;
            end
            P_CHECK: begin
                hit = (m_y >= ROCKET_Y) && (m_x >= int'(rocketX))
                      && (m_x <= int'(rocketX) + ROCKET_W - 1);
                m_pend = m_pend | abort_now;
                if (hit)                m_ph = P_HIT;
                else if (m_y > BOTTOM_Y) model_retire();
                else begin m_col = BOMB_COL; m_ph = P_DRAW; end
            end
            default: model_retire();
        endcase
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check("busy",      32'(busy),      32'(m_ph != P_IDLE));
        check("fireAck",   32'(fireAck),   32'(m_ph == P_LOAD));
        check("drawEn",    32'(drawEn),    32'(m_ph == P_DRAW || m_ph == P_ERASE));
        check("playerHit", 32'(playerHit), 32'(m_ph == P_HIT));
        check("bombX",     32'(bombX),     32'(m_x));
        check("bombY",     32'(bombY),     32'(m_y));
        check("colour",    32'(colour),    32'(m_col));
    endtask

    task automatic fire(input logic [7:0] fx, input logic [6:0] fy, output int n);
        fireReq = 1'b1; fireX = fx; fireY = fy; n = 0;
        do begin tick(); n++; end while (fireAck !== 1'b1 && n < 64);
        check("fire_acked", 32'(fireAck), 32'd1);
        fireReq = 1'b0;
    endtask

    task automatic run_flight(output int hits, output int draws);
        int n = 0;
        hits = 0; draws = 0;
        while (busy === 1'b1 && n < 400) begin
            tick(); n++;
            if (playerHit === 1'b1) hits++;
            if (drawEn === 1'b1 && colour === 3'b101) draws++;
        end
        check("flight_ends", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, h, d;
        reset = 1'b0; fireReq = 1'b0; abort = 1'b0;
        fireX = 8'd0; fireY = 7'd0; rocketX = 8'd100;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Spawn, first draw, erase and next draw one step lower.
        fire(8'd40, 7'd30, n);
        tick();
        check("spawn_draw", 32'(drawEn), 32'd1);
        check("spawn_y",    32'(bombY),  32'd30);
        check("spawn_col",  32'(colour), 32'd5);
        repeat (5) tick();
        check("erase_en",   32'(drawEn), 32'd1);
        check("erase_col",  32'(colour), 32'd0);
        repeat (3) tick();
        check("step_draw",  32'(drawEn), 32'd1);
        check("step_y",     32'(bombY),  32'd33);

        // Reset mid-flight, then an immediate accept.
        tick();
        rocketX = 8'd45;
        reset = 1'b0; tick(); reset = 1'b1;
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_y",     32'(bombY),  32'd0);
        check("rst_draw",  32'(drawEn), 32'd0);
        fire(8'd50, 7'd99, n);
        check("rst_ack_latency", 32'(n), 32'd1);
        run_flight(h, d);
        check("hit_count", 32'(h), 32'd1);
        check("hit_draws", 32'(d), 32'd2);

        fire(8'd53, 7'd99, n); run_flight(h, d);
        check("edge53_hits",  32'(h), 32'd0);
        check("edge53_draws", 32'(d), 32'd7);
        fire(8'd52, 7'd99, n); run_flight(h, d);
        check("edge52_hits",  32'(h), 32'd1);
        rocketX = 8'd252;
        fire(8'd255, 7'd99, n); run_flight(h, d);
        check("nowrap_hits",  32'(h), 32'd1);

        // Bottom retire, then cooldown gap with fireReq held.
        rocketX = 8'd100;
        fire(8'd10, 7'd114, n); run_flight(h, d);
        check("bottom_hits",  32'(h), 32'd0);
        check("bottom_draws", 32'(d), 32'd2);
        fire(8'd10, 7'd114, n);
        check("cooldown_gap", 32'(n), 32'd16);

        // Abort while waiting: erase next cycle, then idle.
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_erase",    32'(drawEn), 32'd1);
        check("abort_erase_c",  32'(colour), 32'd0);
        check("abort_erase_y",  32'(bombY),  32'd114);
        tick();
        check("abort_idle",     32'(busy),   32'd0);

        // Abort coinciding with a hit decision.
        rocketX = 8'd45;
        fire(8'd50, 7'd102, n);
        n = 0;
        while (m_ph != P_CHECK && n < 40) begin tick(); n++; end
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_hit_pulse", 32'(playerHit), 32'd1);
        tick();
        check("abort_hit_idle",  32'(busy), 32'd0);
        fire(8'd50, 7'd60, n);
        tick(); tick(); tick();
        check("no_stale_abort",  32'(drawEn), 32'd0);
        run_flight(h, d);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) != 0);
            abort = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) begin
                fireX = 8'($urandom);
                fireY = 7'($urandom_range(60, 127));
            end
            if ($urandom_range(0, 15) == 0) rocketX = fireX - 8'($urandom_range(0, 10));
            fireReq = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
